rst_release_sequencer: RTL and testbench
========================================

Name: rst_release_sequencer

Overview:
- Sits directly downstream of the two-flop reset synchronizer in each clock domain; consumes its synchronized, active-low reset.
- Releases a set of per-block active-low resets one at a time, in a fixed order, with a minimum hold time and a programmable gap. This avoids simultaneous wake-up of all blocks (inrush and ordering hazards).
- Also provides a software-requested re-sequence and sequence status flags.

Parameters:
- NUM_OUTS, 4, number of downstream reset outputs (at least 2).
- CNT_WIDTH, 8, width of the hold/gap counter and of STEP_DLY.
- HOLD_CYCLES, 16, edges with reset inactive before output 0 releases. Range 1..2^CNT_WIDTH-1.

Ports:
- CLK  input  1  domain clock.
- RST  input  1  reset; synchronous, active-low; driven by the synchronizer's SYNC_RST.
- SOFT_RST_REQ  input  1  level; while high, forces re-sequencing.
- STEP_DLY  input  CNT_WIDTH  gap in cycles between successive releases; 0 is treated as 1.
- RST_OUT_N  output  NUM_OUTS  per-block active-low resets; bit 0 releases first.
- SEQ_BUSY  output  1  high while any RST_OUT_N bit is still asserted.
- SEQ_DONE  output  1  high once all bits are released.

Behaviour:
- All outputs are registered. Reset is synchronous: any edge sampling RST=0 sets RST_OUT_N=0, SEQ_DONE=0, SEQ_BUSY=1, state=HOLD, counter=0, index=0.
- FSM states:
  - HOLD: counting HOLD_CYCLES.
  - STEP: releasing bits 1..NUM_OUTS-1.
  - DONE: idle.
- Start edge E1: the first edge sampling RST=1 and SOFT_RST_REQ=0 after any reset or soft request. Edges are numbered E1, E2, ... from there.
- Gap G: STEP_DLY is sampled at E1 into G (0 maps to 1). G is frozen until the next restart; later changes to STEP_DLY have no effect on the running sequence.
- Release timing:
  - At E_HOLD_CYCLES, RST_OUT_N[0] goes 1 and the FSM moves HOLD -> STEP (or -> DONE if NUM_OUTS=1 is ever used).
  - In STEP, RST_OUT_N[k] goes 1 at edge E_(HOLD_CYCLES + k*G) for k = 1..NUM_OUTS-1.
  - Once released, a bit stays 1 until reset or soft request; bits release strictly in ascending order.
- Completion: at the edge releasing the last bit, SEQ_DONE becomes 1 and SEQ_BUSY becomes 0 in the same cycle, and the FSM enters DONE. Invariant: SEQ_BUSY = ~SEQ_DONE at all times.
- DONE: holds all outputs and ignores STEP_DLY.
- SOFT_RST_REQ:
  - Any edge sampling it high (RST=1), in any state, has the same effect as RST=0: all outputs return to reset values, counter and index clear, state=HOLD.
  - While it is held high, nothing releases. Counting restarts at the first edge it is sampled low.
- Priority: RST=0 over SOFT_RST_REQ over normal sequencing.
- Counter width: the counter never wraps. HOLD_CYCLES and G are both at most 2^CNT_WIDTH-1. The counter clears on every release.
- Reset mid-sequence: immediate re-assertion of all bits at that edge (no partial preservation), then a full sequence from E1.

Test Plan (defaults: HOLD_CYCLES=16, NUM_OUTS=4, CNT_WIDTH=8):
1. RST=0 for 3 edges, SOFT_RST_REQ=0 -> RST_OUT_N=4'b0000, SEQ_BUSY=1, SEQ_DONE=0 after the first sampled edge.
2. Release RST with STEP_DLY=4 -> RST_OUT_N goes 0001 at E16, 0011 at E20, 0111 at E24, 1111 at E28. SEQ_DONE=1 and SEQ_BUSY=0 from E28, with nothing changing before E16.
3. STEP_DLY=0 -> G=1: RST_OUT_N goes 0001, 0011, 0111, 1111 at E16, E17, E18, E19 respectively.
4. STEP_DLY=4 at E1, changed to 9 at E5 -> release edges stay at 16/20/24/28.
5. In DONE, SOFT_RST_REQ high for 10 edges -> RST_OUT_N=0000 and SEQ_DONE=0 from the first high edge. Bit 0 releases at the 16th edge after the request drops.
6. Mid-sequence: RST=0 at E22 (outputs 0011) -> 0000 after E22, SEQ_DONE=0. After RST returns, the full 16/20/24/28 schedule repeats from the new E1.

Source files
------------

// File: rtl/rst_release_sequencer.sv
// ---------------------------------------------------------------------------
// rst_release_sequencer
//
// Purpose:
//   This block sits downstream of a domain's reset synchronizer. It releases
//   a set of per-block active-low resets one at a time, in ascending bit
//   order. Staggering the releases keeps downstream blocks from waking up
//   together, which avoids inrush current and ordering hazards.
//   - Bit 0 is released after HOLD_CYCLES edges with reset inactive.
//   - Each later bit follows after a gap of G edges. G is latched from
//     STEP_DLY on the start edge, and a value of 0 is treated as 1.
//   - A level-sensitive software request restarts the whole sequence.
//
// Ports:
//   CLK           in   domain clock
//   RST           in   synchronous active-low reset (from synchronizer)
//   SOFT_RST_REQ  in   level; while high, holds everything in reset
//   STEP_DLY      in   [CNT_WIDTH] gap between successive releases
//   RST_OUT_N     out  [NUM_OUTS] per-block active-low resets, bit 0 first
//   SEQ_BUSY      out  high while any RST_OUT_N bit is still low
//   SEQ_DONE      out  high once every RST_OUT_N bit is released
// ---------------------------------------------------------------------------
module rst_release_sequencer #(
  parameter int NUM_OUTS    = 4,
  parameter int CNT_WIDTH   = 8,
  parameter int HOLD_CYCLES = 16
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 SOFT_RST_REQ,
  input  logic [CNT_WIDTH-1:0] STEP_DLY,
  output logic [NUM_OUTS-1:0]  RST_OUT_N,
  output logic                 SEQ_BUSY,
  output logic                 SEQ_DONE
);

  localparam int IDX_W = (NUM_OUTS > 1) ? $clog2(NUM_OUTS) : 1;
  localparam logic [CNT_WIDTH-1:0] HOLD_LAST = CNT_WIDTH'(HOLD_CYCLES - 1);
  localparam logic [IDX_W-1:0]     LAST_IDX  = IDX_W'(NUM_OUTS - 1);

  typedef enum logic [1:0] {
    S_HOLD = 2'd0,
    S_STEP = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [CNT_WIDTH-1:0]  gap_q, gap_d;
  logic                  first_q, first_d;  // next active edge is E1
  logic [NUM_OUTS-1:0]   out_q, out_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    gap_d   = gap_q;
    first_d = first_q;
    out_d   = out_q;
    busy_d  = busy_q;
    done_d  = done_q;

    if (SOFT_RST_REQ) begin
      // Same effect as a hardware reset. Counting resumes on the first edge
      // that samples the request low.
      state_d = S_HOLD;
      cnt_d   = '0;
      idx_d   = '0;
      first_d = 1'b1;
      out_d   = '0;
      busy_d  = 1'b1;
      done_d  = 1'b0;
    end else begin
      unique case (state_q)
        S_HOLD: begin
          // Freeze the gap at E1 so later STEP_DLY changes cannot disturb
          // a sequence that is already running.
          if (first_q) begin
            gap_d   = (STEP_DLY == '0) ? CNT_WIDTH'(1) : STEP_DLY;
            first_d = 1'b0;
          end
          // At edge En the counter holds n-1, so this fires on E_HOLD_CYCLES.
          if (cnt_q == HOLD_LAST) begin
            out_d[0] = 1'b1;
            cnt_d    = '0;
            idx_d    = IDX_W'(1);
            if (NUM_OUTS == 1) begin
              state_d = S_DONE;
              busy_d  = 1'b0;
              done_d  = 1'b1;
            end else begin
              state_d = S_STEP;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end

        S_STEP: begin
          if (cnt_q == gap_q - 1'b1) begin
            out_d[idx_q] = 1'b1;
            cnt_d        = '0;
            if (idx_q == LAST_IDX) begin
              state_d = S_DONE;
              busy_d  = 1'b0;
              done_d  = 1'b1;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end

        S_DONE: ;

        default: begin
          state_d = S_HOLD;
          cnt_d   = '0;
          idx_d   = '0;
          first_d = 1'b1;
          out_d   = '0;
          busy_d  = 1'b1;
          done_d  = 1'b0;
        end
      endcase
    end
  end

  // gap_q is not reset: it is always loaded at E1, before S_STEP can use it.
  always_ff @(posedge CLK) begin
    gap_q <= gap_d;
    if (!RST) begin
      state_q <= S_HOLD;
      cnt_q   <= '0;
      idx_q   <= '0;
      first_q <= 1'b1;
      out_q   <= '0;
      busy_q  <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      first_q <= first_d;
      out_q   <= out_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign RST_OUT_N = out_q;
  assign SEQ_BUSY  = busy_q;
  assign SEQ_DONE  = done_q;

endmodule

// File: tb/tb_rst_release_sequencer.sv
// ---------------------------------------------------------------------------
// tb_rst_release_sequencer
//
// Purpose:
//   Directed, self-checking bench for rst_release_sequencer with its default
//   parameters (HOLD_CYCLES=16, NUM_OUTS=4, CNT_WIDTH=8).
//   - The expected release pattern is computed from edge number n (counted
//     from E1) and the frozen gap G.
//   - Bit 0 is released at E16. Bit k is released at E(16 + k*G).
// ---------------------------------------------------------------------------
module tb_rst_release_sequencer;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       SOFT_RST_REQ = 1'b0;
  logic [7:0] STEP_DLY = 8'd0;
  logic [3:0] RST_OUT_N;
  logic       SEQ_BUSY;
  logic       SEQ_DONE;

  int n_cmp = 0;
  int n_bad = 0;

  rst_release_sequencer #(
    .NUM_OUTS   (4),
    .CNT_WIDTH  (8),
    .HOLD_CYCLES(16)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .SOFT_RST_REQ(SOFT_RST_REQ),
    .STEP_DLY    (STEP_DLY),
    .RST_OUT_N   (RST_OUT_N),
    .SEQ_BUSY    (SEQ_BUSY),
    .SEQ_DONE    (SEQ_DONE)
  );

  always #5 CLK = ~CLK;

  // Advance one active edge, then sample away from it.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Expected RST_OUT_N after edge En with gap g.
  function automatic int exp_mask(input int n, input int g);
    int c;
    if (n < 16) return 0;
    c = 1 + (n - 16) / g;
    if (c > 4) c = 4;
    return (1 << c) - 1;
  endfunction

  // Check the reset/idle state of all three outputs.
  task automatic check_reset_state(input string tag);
    check({tag, "_out"},  int'(RST_OUT_N), 0);
    check({tag, "_busy"}, int'(SEQ_BUSY),  1);
    check({tag, "_done"}, int'(SEQ_DONE),  0);
  endtask

  // Step through edges E_from..E_to and check all outputs after each edge.
  task automatic run_edges(input string tag, input int from, input int to, input int g);
    int m;
    for (int n = from; n <= to; n++) begin
      tick();
      m = exp_mask(n, g);
      check($sformatf("%s_E%0d_out", tag, n), int'(RST_OUT_N), m);
      check($sformatf("%s_E%0d_done", tag, n), int'(SEQ_DONE), (m == 15) ? 1 : 0);
      check($sformatf("%s_E%0d_busy", tag, n), int'(SEQ_BUSY), (m == 15) ? 0 : 1);
    end
  endtask

  initial begin
    // 1: reset held low for three edges
    RST = 1'b0;
    SOFT_RST_REQ = 1'b0;
    STEP_DLY = 8'd4;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_reset_state($sformatf("t1_rst%0d", i));
    end

    // 2: release with G=4, then confirm DONE holds
    RST = 1'b1;
    STEP_DLY = 8'd4;
    run_edges("t2", 1, 32, 4);

    // 3: STEP_DLY=0 behaves as G=1
    RST = 1'b0;
    tick();
    check_reset_state("t3_rst");
    RST = 1'b1;
    STEP_DLY = 8'd0;
    run_edges("t3", 1, 21, 1);

    // 4: STEP_DLY changed after E4 must not affect the running sequence
    RST = 1'b0;
    tick();
    check_reset_state("t4_rst");
    RST = 1'b1;
    STEP_DLY = 8'd4;
    run_edges("t4a", 1, 4, 4);
    STEP_DLY = 8'd9;
    run_edges("t4b", 5, 30, 4);

    // 5: soft request in DONE for 10 edges, then a full re-sequence
    SOFT_RST_REQ = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check_reset_state($sformatf("t5_soft%0d", i));
    end
    SOFT_RST_REQ = 1'b0;
    STEP_DLY = 8'd4;
    run_edges("t5", 1, 30, 4);

    // 6: hardware reset at E22 in the middle of a sequence
    RST = 1'b0;
    tick();
    check_reset_state("t6_pre");
    RST = 1'b1;
    STEP_DLY = 8'd4;
    run_edges("t6a", 1, 21, 4);
    RST = 1'b0;
    tick();
    check_reset_state("t6_mid");
    RST = 1'b1;
    run_edges("t6b", 1, 30, 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
